mlp_seq_ctrl: RTL and testbench

MLP_SEQ_CTRL -- requirements
Module: mlp_seq_ctrl

---
 rtl/mlp_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_mlp_seq_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_seq_ctrl.sv
// Layer sequencer for a fully-connected MLP: per layer it clears the accumulators,
// streams input activations and weight rows, drains the read pipe, then writes results.
module mlp_seq_ctrl #(
    parameter int NUM_LAYERS = 5,
    parameter int DIM_W      = 10,
    parameter logic [DIM_W*(NUM_LAYERS+1)-1:0] LAYER_DIMS =
        {10'd10, 10'd16, 10'd32, 10'd32, 10'd64, 10'd784},
    parameter int RD_LAT     = 1,
    parameter int Y_STRIDE   = 4,
    parameter int Y_ADDR_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                stall_i,
    output logic                done_intr_o,
    output logic                done_led_o,
    output logic                busy_o,
    output logic                src_en_o,
    output logic [1:0]          src_sel_o,
    output logic [DIM_W-1:0]    src_addr_o,
    output logic                w_en_o,
    output logic [2:0]          w_layer_o,
    output logic [DIM_W-1:0]    w_addr_o,
    output logic                acc_clr_o,
    output logic                acc_en_o,
    output logic [DIM_W-1:0]    acc_sel_o,
    output logic                relu_o,
    output logic                dst_wr_en_o,
    output logic [1:0]          dst_sel_o,
    output logic [DIM_W-1:0]    dst_addr_o,
    output logic                y_buf_en,
    output logic                y_buf_wr_en,
    output logic [Y_ADDR_W-1:0] y_buf_addr
);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_DRAIN, S_WB, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         l_q;
    logic [DIM_W-1:0]   k_q, j_q;
    logic [2:0]         drain_q;
    logic               done_led_q;
    logic [RD_LAT-1:0]  acc_pipe_q;

    // Dimension table padded to 9 entries so a 3-bit layer index plus one never leaves it.
    logic [DIM_W-1:0] dim_tab [9];
    for (genvar gi = 0; gi < 9; gi++) begin : g_dim
        if (gi <= NUM_LAYERS) begin : g_val
            assign dim_tab[gi] = LAYER_DIMS[gi*DIM_W +: DIM_W];
        end else begin : g_pad
            assign dim_tab[gi] = '0;
        end
    end

    logic [3:0]       l_idx, l_nxt_idx;
    logic [DIM_W-1:0] in_dim, out_dim;
    logic             last_layer, load_last, drain_last, wb_last;

    assign l_idx      = {1'b0, l_q};
    assign l_nxt_idx  = l_idx + 4'd1;
    assign in_dim     = dim_tab[l_idx];
    assign out_dim    = dim_tab[l_nxt_idx];
    assign last_layer = (l_q == 3'(NUM_LAYERS - 1));
    assign load_last  = !stall_i && (k_q == in_dim - DIM_W'(1));
    assign drain_last = (drain_q == 3'(RD_LAT - 1));
    assign wb_last    = !stall_i && (j_q == out_dim - DIM_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i)    state_d = S_CLR;
            S_CLR:                   state_d = S_LOAD;
            S_LOAD:  if (load_last)  state_d = S_DRAIN;
            S_DRAIN: if (drain_last) state_d = S_WB;
            S_WB:    if (wb_last)    state_d = last_layer ? S_DONE : S_CLR;
            S_DONE:                  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Layer/input/output counters and the sticky completion flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q        <= '0;
            k_q        <= '0;
            j_q        <= '0;
            drain_q    <= '0;
            done_led_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    l_q        <= '0;
                    done_led_q <= 1'b0;
                end
                S_CLR: begin
                    k_q     <= '0;
                    j_q     <= '0;
                    drain_q <= '0;
                end
                S_LOAD:  if (!stall_i) k_q <= k_q + DIM_W'(1);
                S_DRAIN: drain_q <= drain_q + 3'd1;
                S_WB: if (!stall_i) begin
                    j_q <= j_q + DIM_W'(1);
                    if (wb_last && !last_layer) l_q <= l_q + 3'd1;
                end
                S_DONE:  done_led_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Accumulate strobe tracks each issued read through the buffer latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_pipe_q <= '0;
        end else begin
            acc_pipe_q[0] <= (state_q == S_LOAD) && !stall_i;
            for (int i = 1; i < RD_LAT; i++) acc_pipe_q[i] <= acc_pipe_q[i-1];
        end
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_intr_o = (state_q == S_DONE);
        done_led_o  = done_led_q || (state_q == S_DONE);
        src_en_o    = (state_q == S_LOAD) && !stall_i;
        w_en_o      = src_en_o;
        src_addr_o  = (state_q == S_LOAD) ? k_q : '0;
        w_addr_o    = src_addr_o;
        w_layer_o   = busy_o ? l_q : 3'd0;
        src_sel_o   = 2'd0;
        if (busy_o && l_q != 3'd0) src_sel_o = l_q[0] ? 2'd1 : 2'd2;
        acc_clr_o   = (state_q == S_CLR);
        acc_en_o    = acc_pipe_q[RD_LAT-1];
        acc_sel_o   = (state_q == S_WB) ? j_q : '0;
        dst_addr_o  = acc_sel_o;
        relu_o      = busy_o && !last_layer;
        dst_wr_en_o = (state_q == S_WB) && !stall_i;
        dst_sel_o   = 2'd0;
        if (busy_o) dst_sel_o = last_layer ? 2'd2 : {1'b0, l_q[0]};
        y_buf_en    = dst_wr_en_o && last_layer;
        y_buf_wr_en = y_buf_en;
        y_buf_addr  = '0;
        if (state_q == S_WB && last_layer)
            y_buf_addr = Y_ADDR_W'(j_q) * Y_ADDR_W'(Y_STRIDE);
    end

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Bench for mlp_seq_ctrl: a phase-level model predicts read/write/y streams and timing,
// with a second instance (RD_LAT=3, small network) checked cycle by cycle.
module tb_mlp_seq_ctrl;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0, stall_i = 1'b0;
  logic done_intr_o, done_led_o, busy_o, src_en_o, w_en_o, acc_clr_o, acc_en_o;
  logic relu_o, dst_wr_en_o, y_buf_en, y_buf_wr_en;
  logic [1:0] src_sel_o, dst_sel_o;
  logic [2:0] w_layer_o;
  logic [9:0] src_addr_o, w_addr_o, acc_sel_o, dst_addr_o;
  logic [31:0] y_buf_addr;

  logic d3_start = 1'b0, d3_stall = 1'b0;
  logic d3_done_intr, d3_done_led, d3_busy, d3_src_en, d3_w_en, d3_acc_clr, d3_acc_en;
  logic d3_relu, d3_dst_wr_en, d3_y_en, d3_y_wr_en;
  logic [1:0] d3_src_sel, d3_dst_sel;
  logic [2:0] d3_w_layer;
  logic [9:0] d3_src_addr, d3_w_addr, d3_acc_sel, d3_dst_addr;
  logic [31:0] d3_y_addr;

  always #5 clk = ~clk;

  mlp_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stall_i(stall_i),
    .done_intr_o(done_intr_o), .done_led_o(done_led_o), .busy_o(busy_o),
    .src_en_o(src_en_o), .src_sel_o(src_sel_o), .src_addr_o(src_addr_o),
    .w_en_o(w_en_o), .w_layer_o(w_layer_o), .w_addr_o(w_addr_o),
    .acc_clr_o(acc_clr_o), .acc_en_o(acc_en_o), .acc_sel_o(acc_sel_o), .relu_o(relu_o),
    .dst_wr_en_o(dst_wr_en_o), .dst_sel_o(dst_sel_o), .dst_addr_o(dst_addr_o),
    .y_buf_en(y_buf_en), .y_buf_wr_en(y_buf_wr_en), .y_buf_addr(y_buf_addr)
  );

  mlp_seq_ctrl #(
    .NUM_LAYERS(2), .DIM_W(10), .LAYER_DIMS({10'd3, 10'd5, 10'd4}), .RD_LAT(3)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(d3_start), .stall_i(d3_stall),
    .done_intr_o(d3_done_intr), .done_led_o(d3_done_led), .busy_o(d3_busy),
    .src_en_o(d3_src_en), .src_sel_o(d3_src_sel), .src_addr_o(d3_src_addr),
    .w_en_o(d3_w_en), .w_layer_o(d3_w_layer), .w_addr_o(d3_w_addr),
    .acc_clr_o(d3_acc_clr), .acc_en_o(d3_acc_en), .acc_sel_o(d3_acc_sel), .relu_o(d3_relu),
    .dst_wr_en_o(d3_dst_wr_en), .dst_sel_o(d3_dst_sel), .dst_addr_o(d3_dst_addr),
    .y_buf_en(d3_y_en), .y_buf_wr_en(d3_y_wr_en), .y_buf_addr(d3_y_addr)
  );

  logic [89:0] all_outs;
  assign all_outs = {done_intr_o, done_led_o, busy_o, src_en_o, src_sel_o, src_addr_o,
                     w_en_o, w_layer_o, w_addr_o, acc_clr_o, acc_en_o, acc_sel_o, relu_o,
                     dst_wr_en_o, dst_sel_o, dst_addr_o, y_buf_en, y_buf_wr_en, y_buf_addr};

  int n_checks = 0;
  int n_errors = 0;
  int dims [6] = '{784, 64, 32, 32, 16, 10};
  bit stall_pat [MAXC];

  logic [31:0] exp_rd_q[$], exp_wr_q[$], exp_y_q[$];
  logic [31:0] obs_rd_q[$], obs_wr_q[$], obs_y_q[$];
  logic [9:0]  obs_src_addr [MAXC];
  int exp_done, obs_done, n_done, acc_cnt, clr_cnt, first_clr, side_bad, en_in_stall;
  logic led_c1, post_busy1, post_busy2, post_clr2;
  logic [89:0] abort_snap;
  bit timeout;

  // Reference model: walks the layers phase by phase against the stall pattern.
  task automatic build_model();
    int t, k, j, ssel, dsel;
    bit last;
    exp_rd_q.delete(); exp_wr_q.delete(); exp_y_q.delete();
    t = 1;
    for (int l = 0; l < 5; l++) begin
      last = (l == 4);
      ssel = (l == 0) ? 0 : 1 + ((l - 1) % 2);
      dsel = last ? 2 : (l % 2);
      t++;
      k = 0;
      while (k < dims[l]) begin
        if (!stall_pat[t]) begin
          exp_rd_q.push_back({7'd0, 3'(l), 2'(ssel), 10'(k), 10'(k)});
          k++;
        end
        t++;
      end
      t += 1;
      j = 0;
      while (j < dims[l+1]) begin
        if (!stall_pat[t]) begin
          exp_wr_q.push_back({9'd0, 2'(dsel), 10'(j), 10'(j), !last});
          if (last) exp_y_q.push_back(32'(j * 4));
          j++;
        end
        t++;
      end
    end
    exp_done = t;
  endtask

  function automatic int diff_count(input int which);
    logic [31:0] e[$], o[$];
    int n, m;
    case (which)
      0: begin e = exp_rd_q; o = obs_rd_q; end
      1: begin e = exp_wr_q; o = obs_wr_q; end
      default: begin e = exp_y_q; o = obs_y_q; end
    endcase
    n = (e.size() > o.size()) ? e.size() - o.size() : o.size() - e.size();
    m = (e.size() < o.size()) ? e.size() : o.size();
    for (int i = 0; i < m; i++) if (e[i] !== o[i]) n++;
    return n;
  endfunction

  // Driver/monitor: pulses (or holds) start, applies stall_pat, records observed traffic.
  task automatic run_dut(input bit hold_start, input int abort_cyc);
    int cyc;
    obs_rd_q.delete(); obs_wr_q.delete(); obs_y_q.delete();
    obs_done = -1; n_done = 0; acc_cnt = 0; clr_cnt = 0; first_clr = -1;
    side_bad = 0; en_in_stall = 0; timeout = 0;
    post_busy1 = 1'bx; post_busy2 = 1'bx; post_clr2 = 1'bx;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start_i = 1'b0;
    cyc = 1;
    while (1) begin
      stall_i = stall_pat[cyc];
      if (cyc == abort_cyc) rst_n = 1'b0;
      @(negedge clk);
      if (cyc == abort_cyc) begin
        abort_snap = all_outs;
        break;
      end
      if (cyc == 1) led_c1 = done_led_o;
      obs_src_addr[cyc] = src_addr_o;
      if (src_en_o) obs_rd_q.push_back({7'd0, w_layer_o, src_sel_o, src_addr_o, w_addr_o});
      if (src_en_o !== w_en_o) side_bad++;
      if (stall_i && (src_en_o || dst_wr_en_o)) en_in_stall++;
      if (dst_wr_en_o) obs_wr_q.push_back({9'd0, dst_sel_o, dst_addr_o, acc_sel_o, relu_o});
      if (y_buf_en) obs_y_q.push_back(y_buf_addr);
      if (y_buf_en !== y_buf_wr_en) side_bad++;
      acc_cnt += int'(acc_en_o);
      clr_cnt += int'(acc_clr_o);
      if (acc_clr_o && first_clr < 0) first_clr = cyc;
      if (done_intr_o) begin
        n_done++;
        if (obs_done < 0) obs_done = cyc;
      end
      if (obs_done > 0 && cyc == obs_done + 1) post_busy1 = busy_o;
      if (obs_done > 0 && cyc == obs_done + 2) begin
        post_busy2 = busy_o;
        post_clr2 = acc_clr_o;
        break;
      end
      if (cyc >= MAXC - 2) begin
        timeout = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    stall_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++; $display("FAIL idle_after_reset: busy got %b expected 0", busy_o);
    end
  endtask

  task automatic test_nominal();
    int l0_reads;
    for (int i = 0; i < MAXC; i++) stall_pat[i] = 1'b0;
    build_model();
    run_dut(1'b0, 0);
    n_checks++;
    if (timeout) begin n_errors++; $display("FAIL nominal_timeout: got 1 expected 0"); end
    n_checks++;
    if (first_clr !== 1) begin
      n_errors++; $display("FAIL nominal_first_clr: got %0d expected 1", first_clr);
    end
    n_checks++;
    if (obs_done !== 1093 || obs_done !== exp_done) begin
      n_errors++; $display("FAIL nominal_done_cycle: got %0d expected %0d", obs_done, exp_done);
    end
    n_checks++;
    if (n_done !== 1) begin n_errors++; $display("FAIL nominal_done_pulses: got %0d expected 1", n_done); end
    l0_reads = 0;
    foreach (obs_rd_q[i]) if (obs_rd_q[i][24:22] == 3'd0) l0_reads++;
    n_checks++;
    if (l0_reads !== 784) begin n_errors++; $display("FAIL nominal_l0_reads: got %0d expected 784", l0_reads); end
    for (int w = 0; w < 3; w++) begin
      n_checks++;
      if (diff_count(w) !== 0) begin
        n_errors++; $display("FAIL nominal_stream%0d: got %0d diffs expected 0", w, diff_count(w));
      end
    end
    n_checks++;
    if (obs_y_q.size() !== 10 || obs_y_q[obs_y_q.size()-1] !== 32'd36) begin
      n_errors++; $display("FAIL nominal_y_writes: got %0d writes expected 10 ending at 36", obs_y_q.size());
    end
    n_checks++;
    if (acc_cnt !== 928) begin n_errors++; $display("FAIL nominal_acc_en: got %0d expected 928", acc_cnt); end
    n_checks++;
    if (clr_cnt !== 5) begin n_errors++; $display("FAIL nominal_acc_clr: got %0d expected 5", clr_cnt); end
    n_checks++;
    if (side_bad !== 0) begin n_errors++; $display("FAIL nominal_side_enables: got %0d expected 0", side_bad); end
    n_checks++;
    if (done_led_o !== 1'b1 || busy_o !== 1'b0) begin
      n_errors++; $display("FAIL nominal_led_idle: got led=%b busy=%b expected 1 0", done_led_o, busy_o);
    end
  endtask

  task automatic test_stall_fixed();
    int bad;
    for (int i = 0; i < MAXC; i++) stall_pat[i] = (i >= 102 && i <= 106);
    build_model();
    run_dut(1'b0, 0);
    n_checks++;
    if (led_c1 !== 1'b0) begin n_errors++; $display("FAIL stall_led_cleared: got %b expected 0", led_c1); end
    n_checks++;
    if (obs_done !== 1098) begin n_errors++; $display("FAIL stall_done_cycle: got %0d expected 1098", obs_done); end
    bad = 0;
    for (int c = 102; c <= 106; c++) if (obs_src_addr[c] !== 10'd100) bad++;
    n_checks++;
    if (bad !== 0) begin n_errors++; $display("FAIL stall_addr_hold: got %0d bad cycles expected 0", bad); end
    n_checks++;
    if (en_in_stall !== 0) begin n_errors++; $display("FAIL stall_enables: got %0d expected 0", en_in_stall); end
    n_checks++;
    if (diff_count(0) !== 0) begin n_errors++; $display("FAIL stall_reads: got %0d diffs expected 0", diff_count(0)); end
  endtask

  task automatic test_random_stall();
    for (int i = 0; i < MAXC; i++) stall_pat[i] = ($urandom_range(0, 3) == 0);
    build_model();
    run_dut(1'b0, 0);
    n_checks++;
    if (obs_done !== exp_done) begin
      n_errors++; $display("FAIL rand_done_cycle: got %0d expected %0d", obs_done, exp_done);
    end
    for (int w = 0; w < 3; w++) begin
      n_checks++;
      if (diff_count(w) !== 0) begin
        n_errors++; $display("FAIL rand_stream%0d: got %0d diffs expected 0", w, diff_count(w));
      end
    end
    n_checks++;
    if (en_in_stall !== 0 || acc_cnt !== 928) begin
      n_errors++; $display("FAIL rand_enables: got stall_en=%0d acc=%0d expected 0 928", en_in_stall, acc_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    int y_seen;
    for (int i = 0; i < MAXC; i++) stall_pat[i] = 1'b0;
    run_dut(1'b0, 990);
    n_checks++;
    if (abort_snap !== '0) begin n_errors++; $display("FAIL midrun_reset_outs: got %h expected 0", abort_snap); end
    y_seen = obs_y_q.size();
    repeat (3) begin
      @(negedge clk);
      y_seen += int'(y_buf_en);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      y_seen += int'(y_buf_en) + int'(busy_o);
    end
    n_checks++;
    if (y_seen !== 0) begin n_errors++; $display("FAIL midrun_quiet: got %0d activity expected 0", y_seen); end
    build_model();
    run_dut(1'b0, 0);
    n_checks++;
    if (obs_done !== 1093) begin n_errors++; $display("FAIL midrun_rerun_done: got %0d expected 1093", obs_done); end
    n_checks++;
    if (diff_count(1) !== 0) begin n_errors++; $display("FAIL midrun_rerun_writes: got %0d diffs expected 0", diff_count(1)); end
  endtask

  task automatic test_start_held();
    for (int i = 0; i < MAXC; i++) stall_pat[i] = 1'b0;
    build_model();
    run_dut(1'b1, 0);
    n_checks++;
    if (obs_done !== 1093 || n_done !== 1) begin
      n_errors++; $display("FAIL held_done: got cycle %0d pulses %0d expected 1093 1", obs_done, n_done);
    end
    n_checks++;
    if (post_busy1 !== 1'b0) begin n_errors++; $display("FAIL held_idle_gap: got busy %b expected 0", post_busy1); end
    n_checks++;
    if (post_busy2 !== 1'b1 || post_clr2 !== 1'b1) begin
      n_errors++; $display("FAIL held_restart: got busy %b clr %b expected 1 1", post_busy2, post_clr2);
    end
    n_checks++;
    if (clr_cnt !== 6) begin n_errors++; $display("FAIL held_clr_count: got %0d expected 6", clr_cnt); end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_rd_lat3();
    int d3dims [3] = '{4, 5, 3};
    bit st [128];
    bit ea [128];
    bit ew [128];
    int t, k, j, done_t;
    for (int i = 0; i < 128; i++) begin
      st[i] = ($urandom_range(0, 2) == 0);
      ea[i] = 1'b0;
      ew[i] = 1'b0;
    end
    t = 1;
    for (int l = 0; l < 2; l++) begin
      t++;
      k = 0;
      while (k < d3dims[l]) begin
        if (!st[t]) begin ea[t+3] = 1'b1; k++; end
        t++;
      end
      t += 3;
      j = 0;
      while (j < d3dims[l+1]) begin
        if (!st[t]) begin ew[t] = 1'b1; j++; end
        t++;
      end
    end
    done_t = t;
    @(posedge clk); #1 d3_start = 1'b1;
    @(posedge clk); #1 d3_start = 1'b0;
    for (int cyc = 1; cyc <= done_t + 1; cyc++) begin
      d3_stall = st[cyc];
      @(negedge clk);
      n_checks++;
      if (d3_acc_en !== ea[cyc]) begin
        n_errors++; $display("FAIL lat3_acc_en c%0d: got %b expected %b", cyc, d3_acc_en, ea[cyc]);
      end
      n_checks++;
      if (d3_dst_wr_en !== ew[cyc]) begin
        n_errors++; $display("FAIL lat3_wr_en c%0d: got %b expected %b", cyc, d3_dst_wr_en, ew[cyc]);
      end
      n_checks++;
      if (d3_done_intr !== (cyc == done_t)) begin
        n_errors++; $display("FAIL lat3_done c%0d: got %b expected %b", cyc, d3_done_intr, cyc == done_t);
      end
      @(posedge clk); #1;
    end
    d3_stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall_fixed();
    test_random_stall();
    test_reset_midrun();
    test_start_held();
    test_rd_lat3();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
